// File: rtl/sd_emmc_axi_mem_responder_if.sv
// rtl/sd_emmc_axi_mem_responder_if.sv - AXI4 slave bus bundle for the DMA memory responder
interface sd_emmc_axi_mem_responder_if;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/sd_emmc_axi_mem_responder.sv
// rtl/sd_emmc_axi_mem_responder.sv - AXI4 slave RAM responder for the SD/eMMC DMA master port
module sd_emmc_axi_mem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS  = 1024,
  parameter int          RD_LATENCY = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  sd_emmc_axi_mem_responder_if.slave        axi,
  output logic [15:0]                       err_count
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_t;

  state_t           state, state_n;
  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic [7:0]       len, beat;
  logic             dec, prio_rd;
  logic [3:0]       lat;
  logic [1:0]       bresp, rresp;
  logic [31:0]      rdata;
  logic             rlast;

  logic        awready, arready, aw_go, ar_go, w_go, w_end, r_go, err_hit;
  logic [31:0] req_addr, req_off;
  logic [7:0]  req_len;
  logic        req_err;
  logic [IDX_W-1:0] idx_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Loser of an AW/AR collision keeps its valid high and wins the next collision.
  always_comb begin
    awready  = (state == IDLE) && !reset && !(axi.s_axi_arvalid && prio_rd);
    arready  = (state == IDLE) && !reset && !(axi.s_axi_awvalid && !prio_rd);
    aw_go    = awready && axi.s_axi_awvalid;
    ar_go    = arready && axi.s_axi_arvalid;
    w_go     = (state == WR_DATA) && axi.s_axi_wvalid;
    w_end    = axi.s_axi_wlast || (beat == len);
    r_go     = (state == RD_DATA) && axi.s_axi_rready;
    req_addr = aw_go ? axi.s_axi_awaddr : axi.s_axi_araddr;
    req_len  = aw_go ? axi.s_axi_awlen : axi.s_axi_arlen;
    req_off  = req_addr - ADDR_BASE;
    req_err  = (req_addr < ADDR_BASE) ||
               (({3'b000, req_off[31:2]} + {25'd0, req_len}) > 33'(MEM_WORDS - 1));
    idx_inc  = idx + 1'b1;
    err_hit  = ((state == WR_RESP) && axi.s_axi_bready && (bresp != 2'b00)) ||
               (r_go && rlast && (rresp != 2'b00));
    state_n  = state;
    case (state)
      IDLE:    if (aw_go) state_n = WR_DATA;
               else if (ar_go) state_n = RD_WAIT;
      WR_DATA: if (w_go && w_end) state_n = WR_RESP;
      WR_RESP: if (axi.s_axi_bready) state_n = IDLE;
      RD_WAIT: if (lat == 4'd0) state_n = RD_DATA;
      RD_DATA: if (r_go && rlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_rd   <= 1'b0;
      idx       <= '0;
      len       <= 8'd0;
      beat      <= 8'd0;
      dec       <= 1'b0;
      lat       <= 4'd0;
      bresp     <= 2'b00;
      rresp     <= 2'b00;
      rdata     <= 32'd0;
      rlast     <= 1'b0;
      err_count <= 16'd0;
    end else begin
      if (aw_go || ar_go) begin
        idx  <= req_off[IDX_W+1:2];
        len  <= req_len;
        beat <= 8'd0;
        dec  <= req_err;
        lat  <= 4'(RD_LATENCY);
        if (axi.s_axi_awvalid && axi.s_axi_arvalid) prio_rd <= !prio_rd;
      end
      if (w_go) begin
        beat <= beat + 8'd1;
        idx  <= idx_inc;
        if (w_end)
          bresp <= dec ? 2'b11 : ((axi.s_axi_wlast != (beat == len)) ? 2'b10 : 2'b00);
      end
      if (state == RD_WAIT) begin
        if (lat == 4'd0) begin
          rdata <= dec ? 32'd0 : mem[idx];
          rresp <= dec ? 2'b11 : 2'b00;
          rlast <= (len == 8'd0);
        end else begin
          lat <= lat - 4'd1;
        end
      end
      // Prefetch the next beat on handshake so beats stream without bubbles.
      if (r_go && !rlast) begin
        beat  <= beat + 8'd1;
        idx   <= idx_inc;
        rdata <= dec ? 32'd0 : mem[idx_inc];
        rlast <= ((beat + 8'd1) == len);
      end
      if (err_hit && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_go && !dec) begin
      for (int b = 0; b < 4; b++)
        if (axi.s_axi_wstrb[b]) mem[idx][8*b +: 8] <= axi.s_axi_wdata[8*b +: 8];
    end
  end

  assign axi.s_axi_awready = awready;
  assign axi.s_axi_arready = arready;
  assign axi.s_axi_wready  = (state == WR_DATA);
  assign axi.s_axi_bvalid  = (state == WR_RESP);
  assign axi.s_axi_bresp   = bresp;
  assign axi.s_axi_rvalid  = (state == RD_DATA);
  assign axi.s_axi_rdata   = rdata;
  assign axi.s_axi_rresp   = rresp;
  assign axi.s_axi_rlast   = rlast;
endmodule

// File: tb/tb_sd_emmc_axi_mem_responder.sv
// tb/tb_sd_emmc_axi_mem_responder.sv - directed bench with transaction-level memory model
module tb_sd_emmc_axi_mem_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int MW = 1024;
  localparam int RL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] err_count;
  always #5 clock = ~clock;

  sd_emmc_axi_mem_responder_if ifc ();
  sd_emmc_axi_mem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(MW), .RD_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .axi(ifc), .err_count(err_count));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    checks++;
    $display("FAIL timeout_%s actual=no_handshake required=handshake", nm);
  endtask

  // Transaction-level model: memory image, expected beats and responses, error tally.
  typedef struct {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  logic [31:0] mm [MW];
  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  int          m_err = 0;
  int          w_idx, w_len, w_beat;
  bit          w_dec;

  function automatic bit m_dec(input logic [31:0] a, input logic [7:0] l);
    longint w;
    if (a < BASE) return 1'b1;
    w = longint'((a - BASE) >> 2) + longint'(l);
    return w > MW - 1;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      rq.delete();
      bq.delete();
      m_err = 0;
    end else begin
      chk("err_count", {16'd0, err_count}, m_err);
      if (ifc.s_axi_rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", {31'd0, ifc.s_axi_rvalid}, 32'd0);
        else begin
          chk("rdata", ifc.s_axi_rdata, rq[0].data);
          chk("rresp", {30'd0, ifc.s_axi_rresp}, {30'd0, rq[0].resp});
          chk("rlast", {31'd0, ifc.s_axi_rlast}, {31'd0, rq[0].last});
          if (ifc.s_axi_rready) begin
            if (rq[0].last && rq[0].resp != 2'b00 && m_err < 65535) m_err++;
            void'(rq.pop_front());
          end
        end
      end
      if (ifc.s_axi_bvalid) begin
        if (bq.size() == 0) chk("bvalid_unexpected", {31'd0, ifc.s_axi_bvalid}, 32'd0);
        else begin
          chk("bresp", {30'd0, ifc.s_axi_bresp}, {30'd0, bq[0]});
          if (ifc.s_axi_bready) begin
            if (bq[0] != 2'b00 && m_err < 65535) m_err++;
            void'(bq.pop_front());
          end
        end
      end
      if (ifc.s_axi_awvalid && ifc.s_axi_awready) begin
        w_dec  = m_dec(ifc.s_axi_awaddr, ifc.s_axi_awlen);
        w_idx  = int'((ifc.s_axi_awaddr - BASE) >> 2);
        w_len  = int'(ifc.s_axi_awlen);
        w_beat = 0;
      end
      if (ifc.s_axi_wvalid && ifc.s_axi_wready) begin
        if (!w_dec)
          for (int b = 0; b < 4; b++)
            if (ifc.s_axi_wstrb[b]) mm[w_idx + w_beat][8*b +: 8] = ifc.s_axi_wdata[8*b +: 8];
        if (ifc.s_axi_wlast || w_beat == w_len)
          bq.push_back(w_dec ? 2'b11 : ((ifc.s_axi_wlast && w_beat == w_len) ? 2'b00 : 2'b10));
        w_beat++;
      end
      if (ifc.s_axi_arvalid && ifc.s_axi_arready) begin
        bit d;
        int i0;
        rbeat_t e;
        d  = m_dec(ifc.s_axi_araddr, ifc.s_axi_arlen);
        i0 = int'((ifc.s_axi_araddr - BASE) >> 2);
        for (int k = 0; k <= int'(ifc.s_axi_arlen); k++) begin
          e.data = d ? 32'd0 : mm[i0 + k];
          e.resp = d ? 2'b11 : 2'b00;
          e.last = (k == int'(ifc.s_axi_arlen));
          rq.push_back(e);
        end
      end
    end
  end

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    ifc.s_axi_awaddr = a; ifc.s_axi_awlen = l; ifc.s_axi_awvalid = 1'b1;
    do begin @(negedge clock); n++; end while (!ifc.s_axi_awready && n < 100);
    if (!ifc.s_axi_awready) tmo("aw");
    @(posedge clock); #1;
    ifc.s_axi_awvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    ifc.s_axi_araddr = a; ifc.s_axi_arlen = l; ifc.s_axi_arvalid = 1'b1;
    do begin @(negedge clock); n++; end while (!ifc.s_axi_arready && n < 100);
    if (!ifc.s_axi_arready) tmo("ar");
    @(posedge clock); #1;
    ifc.s_axi_arvalid = 1'b0;
  endtask

  task automatic w_beats(input int nb, input int wl, input logic [31:0] d0);
    for (int b = 0; b < nb; b++) begin
      int n = 0;
      ifc.s_axi_wdata = d0 + b; ifc.s_axi_wlast = (b == wl); ifc.s_axi_wvalid = 1'b1;
      do begin @(negedge clock); n++; end while (!ifc.s_axi_wready && n < 100);
      if (!ifc.s_axi_wready) tmo("w");
      @(posedge clock); #1;
    end
    ifc.s_axi_wvalid = 1'b0; ifc.s_axi_wlast = 1'b0;
  endtask

  task automatic b_wait(output logic [1:0] r);
    int n = 0;
    do begin @(negedge clock); n++; end while (!ifc.s_axi_bvalid && n < 100);
    if (!ifc.s_axi_bvalid) tmo("b");
    r = ifc.s_axi_bresp;
    @(posedge clock); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int nb, input int wl,
                          input logic [31:0] d0, output logic [1:0] r);
    aw_phase(a, l);
    w_beats(nb, wl, d0);
    b_wait(r);
  endtask

  task automatic r_consume(input logic [3:0] pat, input int stop_after, output int nb,
                           output logic [31:0] first, output logic [31:0] last_d, output int lat);
    int n = 0;
    int k = 0;
    bit done = 0;
    nb = 0; lat = 0; first = 'x; last_d = 'x;
    ifc.s_axi_rready = pat[0];
    while (!done && n < 300) begin
      @(negedge clock); n++;
      if (ifc.s_axi_rvalid && lat == 0) lat = n - 1;
      if (ifc.s_axi_rvalid && ifc.s_axi_rready) begin
        if (nb == 0) first = ifc.s_axi_rdata;
        last_d = ifc.s_axi_rdata;
        nb++;
        if (ifc.s_axi_rlast) done = 1;
      end
      @(posedge clock); #1;
      if (stop_after > 0 && nb == stop_after) done = 1;
      k++;
      ifc.s_axi_rready = pat[k % 4];
    end
    if (!done) tmo("r");
    ifc.s_axi_rready = 1'b1;
  endtask

  logic [1:0]  r;
  logic [31:0] f, l;
  int          nb, lt;

  initial begin
    ifc.s_axi_awaddr = 0; ifc.s_axi_awlen = 0; ifc.s_axi_awvalid = 0;
    ifc.s_axi_wdata = 0; ifc.s_axi_wstrb = 4'hF; ifc.s_axi_wlast = 0; ifc.s_axi_wvalid = 0;
    ifc.s_axi_bready = 1; ifc.s_axi_araddr = 0; ifc.s_axi_arlen = 0; ifc.s_axi_arvalid = 0;
    ifc.s_axi_rready = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_awready", {31'd0, ifc.s_axi_awready}, 0);
    chk("rst_arready", {31'd0, ifc.s_axi_arready}, 0);
    chk("rst_wready",  {31'd0, ifc.s_axi_wready}, 0);
    chk("rst_bvalid",  {31'd0, ifc.s_axi_bvalid}, 0);
    chk("rst_rvalid",  {31'd0, ifc.s_axi_rvalid}, 0);
    chk("rst_rdata",   ifc.s_axi_rdata, 0);
    chk("rst_rlast",   {31'd0, ifc.s_axi_rlast}, 0);
    chk("rst_bresp",   {30'd0, ifc.s_axi_bresp}, 0);
    chk("rst_err",     {16'd0, err_count}, 0);
    reset = 1'b0;

    for (int blk = 0; blk < 4; blk++) begin
      do_write(BASE + 64 * blk, 8'd15, 16, 15, 16 * blk, r);
      chk("preload_bresp", {30'd0, r}, 0);
    end

    do_write(BASE + 32'h10, 8'd0, 1, 0, 32'hA5A5_0001, r);
    chk("single_bresp", {30'd0, r}, 0);
    ar_phase(BASE + 32'h10, 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("word4", f, 32'hA5A5_0001);

    ifc.s_axi_wstrb = 4'b0011;
    do_write(BASE + 32'h14, 8'd0, 1, 0, 32'hFFFF_FFFF, r);
    ifc.s_axi_wstrb = 4'hF;
    ar_phase(BASE + 32'h14, 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("wstrb_word5", f, 32'h0000_FFFF);

    ar_phase(BASE + 32'h40, 8'd15); r_consume(4'hF, 0, nb, f, l, lt);
    chk("burst_beats", nb, 16); chk("burst_first", f, 16); chk("burst_last", l, 31);
    chk("rd_latency", lt, RL + 1);

    ar_phase(BASE + 32'h40, 8'd15); r_consume(4'b1001, 0, nb, f, l, lt);
    chk("bp_beats", nb, 16); chk("bp_first", f, 16); chk("bp_last", l, 31);
    chk("bp_queue_empty", rq.size(), 0);

    ifc.s_axi_araddr = BASE + 32'hA0; ifc.s_axi_arlen = 0; ifc.s_axi_arvalid = 1;
    ifc.s_axi_awaddr = BASE + 32'hA0; ifc.s_axi_awlen = 0; ifc.s_axi_awvalid = 1;
    @(negedge clock);
    chk("prio1_awready", {31'd0, ifc.s_axi_awready}, 1);
    chk("prio1_arready", {31'd0, ifc.s_axi_arready}, 0);
    @(posedge clock); #1; ifc.s_axi_awvalid = 0;
    w_beats(1, 0, 32'h1111_0040); b_wait(r);
    ar_phase(BASE + 32'hA0, 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("raw1", f, 32'h1111_0040);

    ifc.s_axi_araddr = BASE + 32'hA0; ifc.s_axi_arlen = 0; ifc.s_axi_arvalid = 1;
    ifc.s_axi_awaddr = BASE + 32'hA0; ifc.s_axi_awlen = 0; ifc.s_axi_awvalid = 1;
    @(negedge clock);
    chk("prio2_arready", {31'd0, ifc.s_axi_arready}, 1);
    chk("prio2_awready", {31'd0, ifc.s_axi_awready}, 0);
    @(posedge clock); #1; ifc.s_axi_arvalid = 0;
    r_consume(4'hF, 0, nb, f, l, lt);
    chk("prio2_read_old", f, 32'h1111_0040);
    aw_phase(BASE + 32'hA0, 8'd0); w_beats(1, 0, 32'h2222_0040); b_wait(r);
    ar_phase(BASE + 32'hA0, 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("raw2", f, 32'h2222_0040);

    do_write(BASE + 4 * (MW - 1), 8'd0, 1, 0, 32'hDEAD_BEEF, r);
    chk("top_bresp", {30'd0, r}, 0);
    ar_phase(BASE + 4 * (MW - 1), 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("top_rdata", f, 32'hDEAD_BEEF);
    chk("top_err", {16'd0, err_count}, 0);

    ar_phase(BASE + 4 * (MW - 2), 8'd3); r_consume(4'hF, 0, nb, f, l, lt);
    chk("oor_beats", nb, 4); chk("oor_first", f, 0); chk("oor_last", l, 0);
    chk("oor_err", {16'd0, err_count}, 1);
    do_write(BASE + 32'h100, 8'd1, 1, 0, 32'h5555_0000, r);
    chk("slverr_bresp", {30'd0, r}, 2'b10);
    chk("slverr_err", {16'd0, err_count}, 2);
    do_write(BASE - 4, 8'd0, 1, 0, 32'h0BAD_0BAD, r);
    chk("below_bresp", {30'd0, r}, 2'b11);
    chk("below_err", {16'd0, err_count}, 3);
    ar_phase(BASE + 4 * (MW - 1), 8'd0); r_consume(4'hF, 0, nb, f, l, lt);
    chk("decerr_no_write", f, 32'hDEAD_BEEF);

    ar_phase(BASE + 32'h40, 8'd15); r_consume(4'hF, 5, nb, f, l, lt);
    chk("pre_reset_beats", nb, 5);
    #1 reset = 1'b1;
    #1;
    chk("reset_rvalid", {31'd0, ifc.s_axi_rvalid}, 0);
    chk("reset_err", {16'd0, err_count}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    ar_phase(BASE + 32'h40, 8'd3); r_consume(4'hF, 0, nb, f, l, lt);
    chk("post_reset_beats", nb, 4); chk("post_reset_first", f, 16);
    chk("post_reset_last", l, 19); chk("post_reset_lat", lt, RL + 1);

    repeat (2) @(negedge clock);
    chk("final_rq_empty", rq.size(), 0);
    chk("final_bq_empty", bq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
